// File: rtl/seg7_scan_ctrl_if.sv
// Requester-side bus of the 7-segment scan controller: two requesters offer
// display content, the controller answers with grant ownership and load acks.
interface seg7_scan_ctrl_if;
  logic [1:0]  req;
  logic [31:0] hexs0;
  logic [31:0] hexs1;
  logic [7:0]  point0;
  logic [7:0]  point1;
  logic [7:0]  les0;
  logic [7:0]  les1;
  logic [1:0]  grant;
  logic [1:0]  ack;

  modport master (
    output req, hexs0, hexs1, point0, point1, les0, les1,
    input  grant, ack
  );

  modport slave (
    input  req, hexs0, hexs1, point0, point1, les0, les1,
    output grant, ack
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit 7-segment scan controller with a two-requester round-robin
// arbiter that only switches display ownership at scan-frame boundaries.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int HOLD_FRAMES  = 4,
  parameter int FLASH_FRAMES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  seg7_scan_ctrl_if.slave bus,
  output logic [2:0]      Scan,
  output logic            flash,
  output logic [31:0]     Hexs,
  output logic [7:0]      point,
  output logic [7:0]      LES
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  logic [PW-1:0] pre_cnt;
  logic [FW-1:0] frame_cnt;
  logic [HW-1:0] hold_cnt;
  logic          last_owner;
  logic          tick;
  logic          frame_end;
  state_t        state;
  state_t        state_nxt;

  assign tick      = (pre_cnt == PRE_LAST);
  assign frame_end = tick && (Scan == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt   <= '0;
      Scan      <= '0;
      frame_cnt <= '0;
      flash     <= 1'b1;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      if (tick) Scan <= Scan + 3'd1;
      if (frame_end) begin
        if (frame_cnt == FLASH_LAST) begin
          frame_cnt <= '0;
          flash     <= ~flash;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  // Arbitration decision; only committed on frame_end.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req[0] && bus.req[1]) state_nxt = last_owner ? OWN0 : OWN1;
        else if (bus.req[0])          state_nxt = OWN0;
        else if (bus.req[1])          state_nxt = OWN1;
      end
      OWN0: begin
        if (!bus.req[0])                             state_nxt = bus.req[1] ? OWN1 : IDLE;
        else if ((hold_cnt >= HOLD_MAX) && bus.req[1]) state_nxt = OWN1;
      end
      OWN1: begin
        if (!bus.req[1])                             state_nxt = bus.req[0] ? OWN0 : IDLE;
        else if ((hold_cnt >= HOLD_MAX) && bus.req[0]) state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The ack marks the very cycle the owner's content is captured.
  assign bus.ack = (rst_n && frame_end) ? {state_nxt == OWN1, state_nxt == OWN0} : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bus.grant  <= 2'b00;
      hold_cnt   <= '0;
      last_owner <= 1'b1;
      Hexs       <= '0;
      point      <= '0;
      LES        <= '0;
    end else if (frame_end) begin
      state     <= state_nxt;
      bus.grant <= {state_nxt == OWN1, state_nxt == OWN0};
      if (state_nxt == IDLE) begin
        hold_cnt <= '0;
      end else if (state_nxt != state) begin
        hold_cnt   <= HW'(1);
        last_owner <= (state_nxt == OWN1);
      end else if (hold_cnt < HOLD_MAX) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
      // Content is refreshed every frame while owned; IDLE keeps the last frame.
      if (state_nxt == OWN0) begin
        Hexs  <= bus.hexs0;
        point <= bus.point0;
        LES   <= bus.les0;
      end else if (state_nxt == OWN1) begin
        Hexs  <= bus.hexs1;
        point <= bus.point1;
        LES   <= bus.les1;
      end
    end
  end

endmodule
